// File: rtl/reservoir_sequencer_pkg.sv
// rtl/reservoir_sequencer_pkg.sv - shared state encodings and sizing helper for the reservoir sequencer
package reservoir_sequencer_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_DRIVE = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Width of a virtual-node index; also used by the reservoir and readout stages.
    function automatic int node_idx_w(input int vn);
        return (vn > 1) ? $clog2(vn) : 1;
    endfunction

endpackage

// File: rtl/reservoir_tag_delay.sv
// rtl/reservoir_tag_delay.sv - DEPTH-stage shift register aligning {valid, idx, last} with reservoir dout
module reservoir_tag_delay
    import reservoir_sequencer_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             valid_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             last_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o
);

    logic [IDX_W+1:0] stage_q [DEPTH];

    // Shift the tag one stage per cycle; clear wipes every stage so no stale tag survives a reset.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= {valid_i, idx_i, last_i};
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign {valid_o, idx_o, last_o} = stage_q[DEPTH-1];

endmodule

// File: rtl/reservoir_sequencer.sv
// rtl/reservoir_sequencer.sv - time-multiplexes input samples onto reservoir virtual nodes and tags the results
module reservoir_sequencer
    import reservoir_sequencer_pkg::*;
#(
    parameter int VIRTUAL_NODES = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int RES_LATENCY   = 1,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [CNT_WIDTH-1:0]             num_samples,
    input  logic                             mask_we,
    input  logic [VIRTUAL_NODES-1:0]         mask_wdata,
    input  logic                             s_valid,
    input  logic [DATA_WIDTH-1:0]            s_data,
    output logic                             s_ready,
    output logic [DATA_WIDTH-1:0]            res_din,
    input  logic [DATA_WIDTH-1:0]            res_dout,
    output logic                             m_valid,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic [$clog2(VIRTUAL_NODES)-1:0] m_node,
    output logic                             m_last,
    output logic                             busy,
    output logic                             done
);

    localparam int NIW = node_idx_w(VIRTUAL_NODES);
    localparam int FLW = (RES_LATENCY > 1) ? $clog2(RES_LATENCY) : 1;
    localparam logic [NIW-1:0] LAST_NODE  = NIW'(VIRTUAL_NODES - 1);
    localparam logic [FLW-1:0] LAST_FLUSH = FLW'(RES_LATENCY - 1);

    logic [2:0]               state_q, state_d;
    logic [VIRTUAL_NODES-1:0] mask_q, mask_d;
    logic [NIW-1:0]           node_q, node_d;
    logic [DATA_WIDTH-1:0]    sample_q, sample_d;
    logic [CNT_WIDTH-1:0]     num_q, num_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic [FLW-1:0]           flush_q, flush_d;

    logic                  more_samples;
    logic                  node_last;
    logic                  accept;
    logic [DATA_WIDTH-1:0] neg_sample;
    logic                  tag_valid_in, tag_last_in;
    logic                  tag_valid_out, tag_last_out;
    logic [NIW-1:0]        tag_idx_out;

    logic                  m_valid_q, m_last_q;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic [NIW-1:0]        m_node_q;

    // cnt_q counts samples already accepted, so it is compared against the latched run length.
    assign more_samples = (cnt_q != num_q);
    assign node_last    = (node_q == LAST_NODE);
    assign s_ready      = (state_q == ST_WAIT) ||
                          ((state_q == ST_DRIVE) && node_last && more_samples);
    assign accept       = s_valid && s_ready;
    // Two's-complement negate wraps, so the most negative sample maps to itself.
    assign neg_sample   = ~sample_q + DATA_WIDTH'(1);
    assign res_din      = (state_q == ST_DRIVE) ? (mask_q[node_q] ? sample_q : neg_sample) : '0;
    assign tag_valid_in = (state_q == ST_DRIVE);
    assign tag_last_in  = (state_q == ST_DRIVE) && node_last && !more_samples;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);

    // Next-state logic for the run FSM, counters and mask register.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        node_d   = node_q;
        sample_d = sample_q;
        num_d    = num_q;
        cnt_d    = cnt_q;
        flush_d  = flush_q;
        case (state_q)
            ST_IDLE: begin
                if (mask_we) begin
                    mask_d = mask_wdata;
                end
                if (start) begin
                    num_d   = num_samples;
                    cnt_d   = '0;
                    state_d = (num_samples == '0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (accept) begin
                    sample_d = s_data;
                    cnt_d    = cnt_q + CNT_WIDTH'(1);
                    node_d   = '0;
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                node_d = node_q + NIW'(1);
                if (node_last) begin
                    if (more_samples) begin
                        if (accept) begin
                            // Next sample starts without a bubble cycle.
                            sample_d = s_data;
                            cnt_d    = cnt_q + CNT_WIDTH'(1);
                            node_d   = '0;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end else begin
                        flush_d = '0;
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_q == LAST_FLUSH) begin
                    state_d = ST_DONE;
                end else begin
                    flush_d = flush_q + FLW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers; reset restores an all-positive mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mask_q   <= '1;
            node_q   <= '0;
            sample_q <= '0;
            num_q    <= '0;
            cnt_q    <= '0;
            flush_q  <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            node_q   <= node_d;
            sample_q <= sample_d;
            num_q    <= num_d;
            cnt_q    <= cnt_d;
            flush_q  <= flush_d;
        end
    end

    reservoir_tag_delay #(
        .DEPTH (RES_LATENCY),
        .IDX_W (NIW)
    ) u_tag_delay (
        .clk     (clk),
        .clr_i   (rst),
        .valid_i (tag_valid_in),
        .idx_i   (node_q),
        .last_i  (tag_last_in),
        .valid_o (tag_valid_out),
        .idx_o   (tag_idx_out),
        .last_o  (tag_last_out)
    );

    // Register the returning reservoir state together with its delayed tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            m_node_q  <= '0;
        end else begin
            m_valid_q <= tag_valid_out;
            m_last_q  <= tag_last_out;
            if (tag_valid_out) begin
                m_data_q <= res_dout;
                m_node_q <= tag_idx_out;
            end
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_node  = m_node_q;
    assign m_last  = m_last_q;

endmodule

// File: tb/tb_reservoir_sequencer.sv
// tb/tb_reservoir_sequencer.sv - directed self-checking bench for reservoir_sequencer
module tb_reservoir_sequencer;

    localparam int VN = 10;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst, start, start3, mask_we, s_valid;
    logic [CW-1:0] num_samples;
    logic [VN-1:0] mask_wdata;
    logic [DW-1:0] s_data;

    logic          s_ready, s_ready3, m_valid, m_valid3, m_last, m_last3;
    logic          busy, busy3, done, done3;
    logic [DW-1:0] res_din, res_din3, res_dout, res_dout3, m_data, m_data3;
    logic [3:0]    m_node, m_node3;
    logic [DW-1:0] pipe3 [3];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [VN-1:0] cur_mask;

    int            mv_count, done_count, mv3_count, done3_count, first_mv3_cyc;
    logic [3:0]    log_node [64];
    logic [DW-1:0] log_data [64];
    logic          log_last [64];
    logic [3:0]    log3_node [64];
    logic [DW-1:0] log3_data [64];
    logic          log3_last [64];

    always #5 clk = ~clk;

    reservoir_sequencer #(.VIRTUAL_NODES(VN), .DATA_WIDTH(DW), .RES_LATENCY(1), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .mask_we(mask_we), .mask_wdata(mask_wdata), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .res_din(res_din), .res_dout(res_dout), .m_valid(m_valid),
        .m_data(m_data), .m_node(m_node), .m_last(m_last), .busy(busy), .done(done)
    );

    reservoir_sequencer #(.VIRTUAL_NODES(VN), .DATA_WIDTH(DW), .RES_LATENCY(3), .CNT_WIDTH(CW)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .num_samples(num_samples),
        .mask_we(mask_we), .mask_wdata(mask_wdata), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready3), .res_din(res_din3), .res_dout(res_dout3), .m_valid(m_valid3),
        .m_data(m_data3), .m_node(m_node3), .m_last(m_last3), .busy(busy3), .done(done3)
    );

    // Reservoir models: pure delay lines echoing din after 1 and 3 cycles.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        res_dout <= res_din;
        pipe3[0] <= res_din3;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign res_dout3 = pipe3[2];

    always @(negedge clk) begin
        if (m_valid === 1'b1) begin
            if (mv_count < 64) begin
                log_node[mv_count] = m_node;
                log_data[mv_count] = m_data;
                log_last[mv_count] = m_last;
            end
            mv_count++;
        end
        if (done === 1'b1) done_count++;
        if (m_valid3 === 1'b1) begin
            if (mv3_count == 0) first_mv3_cyc = cyc;
            if (mv3_count < 64) begin
                log3_node[mv3_count] = m_node3;
                log3_data[mv3_count] = m_data3;
                log3_last[mv3_count] = m_last3;
            end
            mv3_count++;
        end
        if (done3 === 1'b1) done3_count++;
    end

    function automatic logic [DW-1:0] exp_din(input logic [VN-1:0] m, input int n, input logic [DW-1:0] d);
        return m[n] ? d : (~d + 32'd1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        mv_count = 0; done_count = 0; mv3_count = 0; done3_count = 0; first_mv3_cyc = -1;
    endtask

    task automatic load_mask(input logic [VN-1:0] m);
        mask_we = 1'b1; mask_wdata = m;
        tick();
        mask_we = 1'b0; cur_mask = m;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checks++; if ({s_ready, res_din, m_valid, m_data, m_node, m_last, busy, done} !== '0) begin
            $display("FAIL reset_outputs: got %h required 0", {s_ready, res_din, m_valid, m_data, m_node, m_last, busy, done}); errors++; end
        checks++; if (dut.mask_q !== 10'h3FF) begin $display("FAIL reset_mask: got %h required 3ff", dut.mask_q); errors++; end
        load_mask(10'h0F0);
        num_samples = 2; start = 1'b1; tick(); start = 1'b0;
        s_valid = 1'b1; s_data = 32'd3; tick(); s_valid = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b1 || res_din === '0) begin $display("FAIL reset_prerun: busy %b res_din %h required busy 1 and nonzero", busy, res_din); errors++; end
        rst = 1'b1;
        repeat (5) tick();
        checks++; if ({s_ready, res_din, m_valid, m_data, m_node, m_last, busy, done} !== '0) begin
            $display("FAIL reset_mid_outputs: got %h required 0", {s_ready, res_din, m_valid, m_data, m_node, m_last, busy, done}); errors++; end
        checks++; if (dut.state_q !== 3'd0) begin $display("FAIL reset_state: got %0d required 0", dut.state_q); errors++; end
        checks++; if (dut.mask_q !== 10'h3FF) begin $display("FAIL reset_mid_mask: got %h required 3ff", dut.mask_q); errors++; end
        rst = 1'b0; cur_mask = 10'h3FF;
        clear_logs();
        repeat (6) tick();
        checks++; if (done_count !== 0 || mv_count !== 0) begin $display("FAIL reset_abort: done %0d m_valid %0d required 0 0", done_count, mv_count); errors++; end
    endtask

    task automatic test_single_sample();
        load_mask(10'b0101010101);
        clear_logs();
        num_samples = 1; start = 1'b1; tick(); start = 1'b0;
        checks++; if (s_ready !== 1'b1) begin $display("FAIL single_wait_ready: got %b required 1", s_ready); errors++; end
        s_valid = 1'b1; s_data = 32'd7; tick(); s_valid = 1'b0;
        for (int n = 0; n < VN; n++) begin
            checks++; if (res_din !== exp_din(cur_mask, n, 32'd7)) begin $display("FAIL single_din node %0d: got %h required %h", n, res_din, exp_din(cur_mask, n, 32'd7)); errors++; end
            if (n < 2) begin
                checks++; if (m_valid !== 1'b0) begin $display("FAIL single_early_valid node %0d: got %b required 0", n, m_valid); errors++; end
            end else if (n == 2) begin
                checks++; if (m_valid !== 1'b1 || m_node !== 4'd0) begin $display("FAIL single_first_valid: valid %b node %0d required 1 0", m_valid, m_node); errors++; end
            end
            tick();
        end
        checks++; if (res_din !== '0 || busy !== 1'b1 || done !== 1'b0) begin $display("FAIL single_flush: din %h busy %b done %b required 0 1 0", res_din, busy, done); errors++; end
        tick();
        checks++; if (done !== 1'b1) begin $display("FAIL single_done: got %b required 1", done); errors++; end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin $display("FAIL single_idle: done %b busy %b required 0 0", done, busy); errors++; end
        tick();
        checks++; if (mv_count !== VN || done_count !== 1) begin $display("FAIL single_counts: m_valid %0d done %0d required 10 1", mv_count, done_count); errors++; end
        for (int i = 0; i < VN; i++) begin
            checks++; if (log_node[i] !== 4'(i) || log_last[i] !== (i == VN-1) || log_data[i] !== exp_din(cur_mask, i, 32'd7)) begin
                $display("FAIL single_out %0d: node %0d last %b data %h required %0d %b %h", i, log_node[i], log_last[i], log_data[i], i, (i == VN-1), exp_din(cur_mask, i, 32'd7)); errors++; end
        end
    endtask

    task automatic test_back_to_back();
        int hs, drv, gap;
        logic fire, fin;
        logic [DW-1:0] exp;
        load_mask(10'b1100110011);
        clear_logs();
        num_samples = 3; start = 1'b1; tick(); start = 1'b0;
        num_samples = 1;
        s_valid = 1'b1; s_data = 32'd1;
        hs = 0; drv = 0; gap = 0; fin = 1'b0;
        for (int c = 0; c < 80 && !fin; c++) begin
            fire = s_valid && s_ready;
            if (res_din !== '0) begin
                exp = exp_din(cur_mask, drv % VN, 32'(drv / VN + 1));
                checks++; if (res_din !== exp) begin $display("FAIL b2b_din %0d: got %h required %h", drv, res_din, exp); errors++; end
                drv++;
            end else if (drv > 0 && drv < 3*VN) begin
                gap++;
            end
            if (done === 1'b1) fin = 1'b1;
            tick();
            if (fire) begin
                hs++;
                if (hs < 3) s_data = 32'(hs + 1); else s_valid = 1'b0;
            end
        end
        s_valid = 1'b0;
        tick(); tick();
        checks++; if (fin !== 1'b1) begin $display("FAIL b2b_timeout: done seen %b required 1", fin); errors++; end
        checks++; if (drv !== 3*VN || gap !== 0 || hs !== 3) begin $display("FAIL b2b_drive: cycles %0d gaps %0d handshakes %0d required 30 0 3", drv, gap, hs); errors++; end
        checks++; if (mv_count !== 3*VN || done_count !== 1) begin $display("FAIL b2b_counts: m_valid %0d done %0d required 30 1", mv_count, done_count); errors++; end
        for (int i = 0; i < 3*VN; i++) begin
            checks++; if (log_node[i] !== 4'(i % VN) || log_last[i] !== (i == 3*VN-1)) begin
                $display("FAIL b2b_tag %0d: node %0d last %b required %0d %b", i, log_node[i], log_last[i], i % VN, (i == 3*VN-1)); errors++; end
        end
    endtask

    task automatic test_stalled_source();
        clear_logs();
        num_samples = 2; start = 1'b1; tick(); start = 1'b0;
        s_valid = 1'b1; s_data = 32'd10; tick(); s_valid = 1'b0;
        for (int n = 0; n < VN; n++) begin
            checks++; if (res_din !== exp_din(cur_mask, n, 32'd10)) begin $display("FAIL stall_din0 node %0d: got %h required %h", n, res_din, exp_din(cur_mask, n, 32'd10)); errors++; end
            tick();
        end
        for (int g = 0; g < 5; g++) begin
            checks++; if (res_din !== '0 || s_ready !== 1'b1) begin $display("FAIL stall_gap %0d: din %h ready %b required 0 1", g, res_din, s_ready); errors++; end
            if (g >= 2) begin
                checks++; if (m_valid !== 1'b0) begin $display("FAIL stall_gap_valid %0d: got %b required 0", g, m_valid); errors++; end
            end
            tick();
        end
        s_valid = 1'b1; s_data = 32'hFFFFFFFD; tick(); s_valid = 1'b0;
        for (int n = 0; n < VN; n++) begin
            checks++; if (res_din !== exp_din(cur_mask, n, 32'hFFFFFFFD)) begin $display("FAIL stall_din1 node %0d: got %h required %h", n, res_din, exp_din(cur_mask, n, 32'hFFFFFFFD)); errors++; end
            tick();
        end
        tick();
        checks++; if (done !== 1'b1) begin $display("FAIL stall_done: got %b required 1", done); errors++; end
        tick(); tick();
        checks++; if (mv_count !== 2*VN) begin $display("FAIL stall_count: got %0d required 20", mv_count); errors++; end
        for (int i = 0; i < VN; i++) begin
            checks++; if (log_node[VN+i] !== 4'(i) || log_data[VN+i] !== exp_din(cur_mask, i, 32'hFFFFFFFD)) begin
                $display("FAIL stall_out %0d: node %0d data %h required %0d %h", i, log_node[VN+i], log_data[VN+i], i, exp_din(cur_mask, i, 32'hFFFFFFFD)); errors++; end
        end
    endtask

    task automatic test_boundary();
        load_mask(10'b1111111110);
        clear_logs();
        num_samples = 1; start = 1'b1; tick(); start = 1'b0;
        s_valid = 1'b1; s_data = 32'h80000000; tick(); s_valid = 1'b0;
        checks++; if (res_din !== 32'h80000000) begin $display("FAIL bound_min_neg: got %h required 80000000", res_din); errors++; end
        repeat (VN + 3) tick();
        num_samples = 1; start = 1'b1; tick(); start = 1'b0;
        mask_we = 1'b1; mask_wdata = 10'h155; tick(); mask_we = 1'b0;
        checks++; if (dut.mask_q !== 10'h3FE) begin $display("FAIL bound_mask_busy: got %h required 3fe", dut.mask_q); errors++; end
        s_valid = 1'b1; s_data = 32'd5; tick(); s_valid = 1'b0;
        for (int n = 0; n < VN; n++) begin
            checks++; if (res_din !== exp_din(10'h3FE, n, 32'd5)) begin $display("FAIL bound_mask_din node %0d: got %h required %h", n, res_din, exp_din(10'h3FE, n, 32'd5)); errors++; end
            tick();
        end
        repeat (3) tick();
        clear_logs();
        num_samples = 0; start = 1'b1; tick(); start = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b1) begin $display("FAIL bound_zero_done: done %b busy %b required 1 1", done, busy); errors++; end
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin $display("FAIL bound_zero_idle: done %b busy %b required 0 0", done, busy); errors++; end
        repeat (3) tick();
        checks++; if (mv_count !== 0 || done_count !== 1) begin $display("FAIL bound_zero_counts: m_valid %0d done %0d required 0 1", mv_count, done_count); errors++; end
    endtask

    task automatic test_latency();
        int hs, drv, first_drive;
        logic fire, fin;
        logic [DW-1:0] exp;
        load_mask(10'b1010011100);
        clear_logs();
        num_samples = 2; start3 = 1'b1; tick(); start3 = 1'b0;
        s_valid = 1'b1; s_data = 32'd9;
        hs = 0; drv = 0; first_drive = -1; fin = 1'b0;
        for (int c = 0; c < 80 && !fin; c++) begin
            fire = s_valid && s_ready3;
            if (res_din3 !== '0) begin
                if (drv == 0) first_drive = cyc;
                drv++;
            end
            if (done3 === 1'b1) fin = 1'b1;
            tick();
            if (fire) begin
                hs++;
                if (hs == 1) s_data = 32'hFFFFFFFC; else s_valid = 1'b0;
            end
        end
        s_valid = 1'b0;
        tick(); tick();
        checks++; if (fin !== 1'b1 || drv !== 2*VN) begin $display("FAIL lat_run: done seen %b drive cycles %0d required 1 20", fin, drv); errors++; end
        checks++; if (first_mv3_cyc - first_drive !== 4) begin $display("FAIL lat_first_valid: offset %0d required 4", first_mv3_cyc - first_drive); errors++; end
        checks++; if (mv3_count !== 2*VN || done3_count !== 1) begin $display("FAIL lat_counts: m_valid %0d done %0d required 20 1", mv3_count, done3_count); errors++; end
        for (int i = 0; i < 2*VN; i++) begin
            exp = exp_din(cur_mask, i % VN, (i < VN) ? 32'd9 : 32'hFFFFFFFC);
            checks++; if (log3_node[i] !== 4'(i % VN) || log3_data[i] !== exp || log3_last[i] !== (i == 2*VN-1)) begin
                $display("FAIL lat_out %0d: node %0d data %h last %b required %0d %h %b", i, log3_node[i], log3_data[i], log3_last[i], i % VN, exp, (i == 2*VN-1)); errors++; end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start3 = 1'b0; mask_we = 1'b0; s_valid = 1'b0;
        num_samples = '0; mask_wdata = '0; s_data = '0; cur_mask = '1;
        clear_logs();
        test_reset();
        test_single_sample();
        test_back_to_back();
        test_stalled_source();
        test_boundary();
        test_latency();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
